// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver: decodes 'W'/'R' frames from the host and issues
// single-cycle write/read requests on the DDR3 controller user interface.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ       = 99_800_000,
    parameter int unsigned BAUD           = 115_200,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        sys_resetn,
    input  logic        uart_rxp,
    input  logic        busy,
    input  logic        data_ready,
    input  logic [15:0] dout,
    output logic [25:0] addr,
    output logic [15:0] din,
    output logic        wr,
    output logic        rd,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        cmd_err
);

    localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_ISSUE, P_WAIT} p_state_t;

    rx_state_t        r_rx_state;
    p_state_t         r_p_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_is_write;
    logic [1:0]       r_byte_cnt;
    logic [TO_W-1:0]  r_gap;
    logic             w_fall;

    assign w_fall = r_rx_d & ~r_sync2;

    // Serial deserialiser; a line held low never re-triggers without a fresh edge
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= R_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1   <= uart_rxp;
            r_sync2   <= r_sync1;
            r_rx_d    <= r_sync2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_bit_cnt <= '0;
                    if (w_fall) r_rx_state <= R_START;
                end
                R_START: begin
                    if (r_bit_cnt == CNT_W'(HALF_CYCLES - 1)) begin
                        r_bit_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= r_sync2 ? R_IDLE : R_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (r_bit_cnt == CNT_W'(BIT_CYCLES - 1)) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_rx_state <= R_STOP;
                        else                   r_bit_idx  <= r_bit_idx + 3'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (r_bit_cnt == CNT_W'(BIT_CYCLES - 1)) begin
                        r_bit_cnt  <= '0;
                        r_rx_state <= R_IDLE;
                        if (r_sync2) begin
                            rx_byte  <= r_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // Frame parser and controller request sequencer
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_p_state  <= P_CMD;
            r_is_write <= 1'b0;
            r_byte_cnt <= '0;
            r_gap      <= '0;
            addr       <= '0;
            din        <= '0;
            wr         <= 1'b0;
            rd         <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            cmd_err    <= 1'b0;
        end else begin
            wr       <= 1'b0;
            rd       <= 1'b0;
            rd_valid <= 1'b0;
            cmd_err  <= 1'b0;
            case (r_p_state)
                P_CMD: begin
                    r_gap      <= '0;
                    r_byte_cnt <= '0;
                    if (rx_valid) begin
                        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                            r_is_write <= (rx_byte == OP_WRITE);
                            r_p_state  <= P_ADDR;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                P_ADDR: begin
                    if (rx_valid) begin
                        addr       <= {addr[17:0], rx_byte};
                        r_gap      <= '0;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= '0;
                            r_p_state  <= r_is_write ? P_DATA : P_ISSUE;
                        end
                    end else if (r_gap == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        cmd_err   <= 1'b1;
                        r_p_state <= P_CMD;
                    end else begin
                        r_gap <= r_gap + TO_W'(1);
                    end
                end
                P_DATA: begin
                    if (rx_valid) begin
                        din        <= {din[7:0], rx_byte};
                        r_gap      <= '0;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd1) r_p_state <= P_ISSUE;
                    end else if (r_gap == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        cmd_err   <= 1'b1;
                        r_p_state <= P_CMD;
                    end else begin
                        r_gap <= r_gap + TO_W'(1);
                    end
                end
                P_ISSUE: begin
                    if (rx_valid) cmd_err <= 1'b1;
                    if (!busy) begin
                        wr        <= r_is_write;
                        rd        <= ~r_is_write;
                        r_p_state <= P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (rx_valid) cmd_err <= 1'b1;
                    if (r_is_write) begin
                        // The request cycle itself is skipped so busy has time to rise
                        if (!wr && !busy) r_p_state <= P_CMD;
                    end else if (data_ready) begin
                        rd_data   <= dout;
                        rd_valid  <= 1'b1;
                        r_p_state <= P_CMD;
                    end
                end
                default: r_p_state <= P_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial frames in, scoreboarded bytes, requests and
// read returns out, with error-pulse tallies checked at checkpoints.
module tb_uart_cmd_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned TIMEOUT  = 3000;
    localparam int unsigned BITC     = CLK_FREQ / BAUD;
    localparam int unsigned HALFC    = BITC / 2;

    typedef struct packed {
        logic        is_wr;
        logic [25:0] addr;
        logic [15:0] din;
    } req_t;

    logic        clk = 1'b0;
    logic        sys_resetn = 1'b0;
    logic        uart_rxp = 1'b1;
    logic        busy = 1'b0;
    logic        data_ready = 1'b0;
    logic [15:0] dout = '0;
    logic [25:0] addr;
    logic [15:0] din;
    logic        wr, rd, rd_valid, rx_valid, frame_err, cmd_err;
    logic [15:0] rd_data;
    logic [7:0]  rx_byte;

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .sys_resetn(sys_resetn), .uart_rxp(uart_rxp), .busy(busy),
        .data_ready(data_ready), .dout(dout), .addr(addr), .din(din), .wr(wr), .rd(rd),
        .rd_valid(rd_valid), .rd_data(rd_data), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .frame_err(frame_err), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          n_cmd_err = 0, n_frame_err = 0, exp_cmd_err = 0, exp_frame_err = 0;
    int          wr_cyc = -1, dr_cyc = -1, fall_cyc = 0;
    logic [15:0] rsp_data = '0;
    logic [7:0]  exp_rx[$];
    req_t        exp_req[$];
    logic [15:0] exp_rd[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops expectations as the DUT produces results
    always @(negedge clk) begin
        if (sys_resetn) begin
            if (cmd_err) n_cmd_err++;
            if (frame_err) n_frame_err++;
            if (rx_valid) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
                else chk("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
            end
            if (wr || rd) begin
                if (wr) wr_cyc = cyc;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 32'({wr, rd}), 32'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("req_kind", 32'({wr, rd}), e.is_wr ? 32'd2 : 32'd1);
                    chk("req_addr", 32'(addr), 32'(e.addr));
                    if (e.is_wr) chk("req_din", 32'(din), 32'(e.din));
                end
            end
            if (rd_valid) begin
                chk("rd_valid_lat", 32'(cyc), 32'(dr_cyc + 1));
                if (exp_rd.size() == 0) chk("rdv_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
                else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
        end
    end

    // Controller model: read data returns 20 cycles after each rd
    initial begin
        forever begin
            @(negedge clk);
            if (rd && sys_resetn) begin
                repeat (20) @(posedge clk);
                #1 data_ready = 1'b1; dout = rsp_data; dr_cyc = cyc;
                @(posedge clk);
                #1 data_ready = 1'b0;
            end
        end
    end

    task automatic bit_time();
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxp = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            bit_time();
        end
        uart_rxp = stop;
        bit_time();
        uart_rxp = 1'b1;
        bit_time();
        bit_time();
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_rx.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_cmd_err"}, 32'(n_cmd_err), 32'(exp_cmd_err));
        chk({tag, "_frame_err"}, 32'(n_frame_err), 32'(exp_frame_err));
    endtask

    initial begin
        idle(5);
        @(negedge clk);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", {din, rd_data}, 32'd0);
        chk("rst_ctl", 32'({rx_byte, wr, rd, rd_valid, rx_valid, frame_err, cmd_err}), 32'd0);
        idle(1);
        sys_resetn = 1'b1;
        idle(20);

        // Plain write
        exp_req.push_back('{1'b1, 26'h0001234, 16'hABCD});
        send_good(8'h57); send_good(8'h00); send_good(8'h00); send_good(8'h12);
        send_good(8'h34); send_good(8'hAB); send_good(8'hCD);
        idle(40);
        chk("wr1_pending", 32'(exp_req.size()), 32'd0);
        chk_errs("wr1");

        // Stray data_ready while idle must not produce rd_valid
        data_ready = 1'b1; dout = 16'hDEAD;
        idle(1);
        data_ready = 1'b0;
        idle(10);

        // Read with upper address bits dropped
        rsp_data = 16'h5678;
        exp_req.push_back('{1'b0, 26'h3000005, 16'h0});
        exp_rd.push_back(16'h5678);
        send_good(8'h52); send_good(8'hFF); send_good(8'h00); send_good(8'h00); send_good(8'h05);
        idle(100);
        chk("rd1_pending", 32'(exp_req.size() + exp_rd.size()), 32'd0);
        chk_errs("rd1");

        // Busy stalls the write; a byte arriving meanwhile is an overrun
        send_good(8'h57); send_good(8'h00); send_good(8'h00); send_good(8'h00);
        send_good(8'h07); send_good(8'h11);
        busy = 1'b1;
        send_good(8'h22);
        send_good(8'h99);
        exp_cmd_err++;
        idle(150);
        exp_req.push_back('{1'b1, 26'h0000007, 16'h1122});
        busy = 1'b0; fall_cyc = cyc;
        idle(10);
        chk("wr_after_busy", 32'(wr_cyc), 32'(fall_cyc + 1));
        chk("busy_pending", 32'(exp_req.size()), 32'd0);
        chk_errs("busy");

        // Bad opcode, bad stop bit, short glitch
        send_good(8'h41);
        exp_cmd_err++;
        send_byte(8'hA5, 1'b0);
        exp_frame_err++;
        uart_rxp = 1'b0;
        idle(HALFC / 2);
        uart_rxp = 1'b1;
        bit_time(); bit_time(); bit_time();
        chk_errs("errs");

        // Timeout mid-frame, then a normal read
        send_good(8'h57); send_good(8'h00);
        idle(TIMEOUT + 100);
        exp_cmd_err++;
        chk_errs("timeout");
        rsp_data = 16'h1357;
        exp_req.push_back('{1'b0, 26'h000002A, 16'h0});
        exp_rd.push_back(16'h1357);
        send_good(8'h52); send_good(8'h00); send_good(8'h00); send_good(8'h00); send_good(8'h2A);
        idle(100);
        chk("rd2_pending", 32'(exp_req.size() + exp_rd.size()), 32'd0);

        // Reset mid-address byte, then a full write
        send_good(8'h57); send_good(8'h3F);
        fork
            send_byte(8'h00, 1'b1);
            begin
                idle(60);
                sys_resetn = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("mid_rst_addr", 32'(addr), 32'd0);
                chk("mid_rst_data", {din, rd_data}, 32'd0);
            end
        join
        sys_resetn = 1'b1;
        idle(40);
        exp_req.push_back('{1'b1, 26'h0010203, 16'hBEEF});
        send_good(8'h57); send_good(8'h00); send_good(8'h01); send_good(8'h02);
        send_good(8'h03); send_good(8'hBE); send_good(8'hEF);
        idle(40);
        chk("wr2_pending", 32'(exp_req.size()), 32'd0);
        chk("rx_pending", 32'(exp_rx.size()), 32'd0);
        chk_errs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART command receiver and memory-request front end for the DDR3 test design. Deserialises 8N1 bytes arriving on the board UART RX pin, decodes fixed-length write/read command frames and issues single-cycle `wr`/`rd` requests on the DDR3 controller user interface (`addr`, `din`, `wr`, `rd`, `busy`, `data_ready`, `dout`). It is the host-to-board counterpart of the existing UART print path, so memory can be poked and peeked from a PC without rebuilding the test FSM.

## Interface
- `CLK_FREQ`, 99_800_000, clock frequency in Hz
- `BAUD`, 115200, UART bit rate; `BIT_CYCLES = CLK_FREQ/BAUD`, integer truncation (866 at defaults), `HALF_CYCLES = BIT_CYCLES/2` (433)
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle gap between bytes of one frame

- `clk` in 1: single clock, same as controller `pclk`
- `sys_resetn` in 1: reset, synchronous, active-low
- `uart_rxp` in 1: asynchronous serial input, idle high
- `busy` in 1: controller busy
- `data_ready` in 1: controller read-data strobe
- `dout` in 16: controller read data
- `addr` out 26: request address, word granularity
- `din` out 16: write data
- `wr` out 1: one-cycle write request
- `rd` out 1: one-cycle read request
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid
- `rd_data` out 16: captured read word
- `rx_valid` out 1: one-cycle pulse per good byte
- `rx_byte` out 8: last good byte
- `frame_err` out 1: one-cycle pulse, stop bit sampled low
- `cmd_err` out 1: one-cycle pulse, bad opcode / overrun / timeout

## Operation
- Reset: every output 0; synchroniser flops 1; RX in R_IDLE, parser in P_CMD; all counters 0.
- `uart_rxp` passes through a 2-flop synchroniser (`rx_s`); edge detect uses one more flop.
- RX FSM: R_IDLE -> R_START on `rx_s` high-to-low. R_START waits `HALF_CYCLES`; `rx_s` low -> R_DATA, else R_IDLE (glitch, no error). R_DATA samples 8 bits LSB first, one every `BIT_CYCLES`. R_STOP samples after a further `BIT_CYCLES`: high -> `rx_byte` loaded, `rx_valid` pulse; low -> `frame_err` pulse, byte discarded. Both -> R_IDLE. A line held low (break) produces no further start until a high-to-low edge.
- Frames (bytes big-endian): write = 0x57 'W', A3, A2, A1, A0, D1, D0; read = 0x52 'R', A3, A2, A1, A0. `addr` = {A3..A0}[25:0]; upper 6 bits discarded. `din` = {D1, D0}.
- Parser FSM: P_CMD (opcode) -> P_ADDR (4 bytes, byte counter) -> P_DATA (2 bytes, write only) -> P_ISSUE -> P_WAIT -> P_CMD.
- P_CMD: opcode other than 0x57/0x52 -> `cmd_err` pulse, stay in P_CMD.
- P_ISSUE: when `busy` is 0, assert `wr` or `rd` for exactly one cycle, then enter P_WAIT. `addr`/`din` are stable from entry to P_ISSUE until the next frame's first address byte.
- P_WAIT write: skip the cycle `wr` is high, then wait `busy` == 0 -> P_CMD.
- P_WAIT read: wait `data_ready`; capture `dout` into `rd_data`, pulse `rd_valid` next cycle -> P_CMD. `data_ready` outside P_WAIT-read is ignored.
- Overrun: `rx_valid` while in P_ISSUE/P_WAIT -> byte dropped, `cmd_err` pulse, state unchanged.
- Timeout: in P_ADDR/P_DATA, gap counter clears on each `rx_valid`. At `TIMEOUT_CYCLES` -> `cmd_err` pulse, P_CMD. No timeout in P_ISSUE/P_WAIT.
- `frame_err` does not abort a frame; only the timeout recovers from a lost byte.

## Timing
- All outputs registered.
- `rx_valid` occurs 2 (synchroniser) + 1 (edge) + `HALF_CYCLES` + 9×`BIT_CYCLES` cycles after the `uart_rxp` falling edge, ±1 cycle.
- Final frame byte `rx_valid` at cycle T: P_ISSUE at T+1; with `busy` low, `wr`/`rd` high at T+2 only.
- `rd_valid` is high the cycle after `data_ready`.
- `sys_resetn` low mid-byte or mid-frame: next cycle everything is at reset values, including a `wr`/`rd` that was pending; the partial frame is lost.

## Test plan
- Send 'W',00,00,12,34,AB,CD with `busy`=0 -> one `wr` pulse, `addr`=0x0001234, `din`=0xABCD, 7 `rx_valid` pulses, no errors.
- Send 'R',FF,00,00,05; `data_ready` 20 cycles after `rd` with `dout`=0x5678 -> one `rd`, `addr`=0x3000005 (bits 31:26 dropped), `rd_valid` with `rd_data`=0x5678.
- Hold `busy`=1 for 500 cycles around the final write byte -> `wr` rises the cycle after `busy` falls; bytes sent meanwhile -> `cmd_err` per byte.
- Byte 0x41 -> `cmd_err`; byte with low stop bit -> `frame_err`, no `rx_valid`; a 100-cycle low glitch -> nothing.
- 'W',00 then silence for `TIMEOUT_CYCLES` -> `cmd_err`; a following full read frame executes normally.
- Assert `sys_resetn`=0 mid-address byte -> all outputs 0 next cycle; a following full write frame executes correctly.
